// File: rtl/jtag_tx_register.sv
// JTAG read-back data register: one-entry holding buffer fed by a valid/ready producer,
// captured with status bits into a DR-length shift register and scanned out LSB-first on TDO.
module jtag_tx_register #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  RESET,
  input  logic                  CLOCK_DR,
  input  logic                  CAPTURE_DR,
  input  logic                  SHIFT_DR,
  input  logic                  UPDATE_DR,
  input  logic                  TDI,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  output logic                  TDO,
  output logic                  CAPTURED,
  output logic                  OVERFLOW
);

  localparam int unsigned ScanLen = DATA_WIDTH + 3;
  localparam int unsigned CntW    = $clog2(DATA_WIDTH + 4);
  localparam logic [CntW-1:0] CntMax = CntW'(ScanLen);

  // Posedge-domain state
  logic [ScanLen-1:0]    shift_reg_q, shift_reg_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_full_q, hold_full_d;
  logic                  ovf_q, ovf_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  captured_q, captured_d;
  logic                  arm_p_q, arm_p_d;
  logic                  short_clr_q, short_clr_d;

  // Negedge-domain state (UPDATE_DR path)
  logic                  arm_n_q;
  logic                  short_set_q;

  // armed and short_err are each split into a posedge half and a negedge half so every
  // flop has a single driver; the XOR of the pair is the logical flag.
  logic armed;
  logic short_err;

  assign armed     = arm_p_q ^ arm_n_q;
  assign short_err = short_set_q ^ short_clr_q;

  always_comb begin
    shift_reg_d = shift_reg_q;
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    ovf_d       = ovf_q;
    bit_cnt_d   = bit_cnt_q;
    arm_p_d     = arm_p_q;
    short_clr_d = short_clr_q;
    captured_d  = CAPTURE_DR & hold_full_q;

    if (CAPTURE_DR) begin
      shift_reg_d = {hold_data_q, short_err, ovf_q, hold_full_q};
      hold_full_d = 1'b0;
      ovf_d       = 1'b0;
      bit_cnt_d   = '0;
      short_clr_d = short_set_q;
      arm_p_d     = arm_n_q ^ hold_full_q;
    end else if (SHIFT_DR) begin
      shift_reg_d = {TDI, shift_reg_q[ScanLen-1:1]};
      if (bit_cnt_q != CntMax) begin
        bit_cnt_d = bit_cnt_q + CntW'(1);
      end
    end

    // Producer side is evaluated after capture so that accept/drop override the clears.
    if (DATA_VALID) begin
      if (hold_full_q) begin
        ovf_d = 1'b1;
      end else begin
        hold_data_d = DATA_IN;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_DR or negedge RESET) begin
    if (!RESET) begin
      shift_reg_q <= '0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      bit_cnt_q   <= '0;
      captured_q  <= 1'b0;
      arm_p_q     <= 1'b0;
      short_clr_q <= 1'b0;
    end else begin
      shift_reg_q <= shift_reg_d;
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      ovf_q       <= ovf_d;
      bit_cnt_q   <= bit_cnt_d;
      captured_q  <= captured_d;
      arm_p_q     <= arm_p_d;
      short_clr_q <= short_clr_d;
    end
  end

  always_ff @(negedge CLOCK_DR or negedge RESET) begin
    if (!RESET) begin
      arm_n_q     <= 1'b0;
      short_set_q <= 1'b0;
    end else if (UPDATE_DR) begin
      if (armed && (bit_cnt_q != CntMax)) begin
        short_set_q <= ~short_clr_q;
      end
      arm_n_q <= arm_p_q;
    end
  end

  assign DATA_READY = ~hold_full_q;
  assign TDO        = shift_reg_q[0];
  assign CAPTURED   = captured_q;
  assign OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_jtag_tx_register.sv
// Self-checking bench for jtag_tx_register: vector table, directed scan sequences and
// randomized traffic against a queue-based reference model.
module tb_jtag_tx_register;

  localparam int W = 16;
  localparam int L = W + 3;

  logic         RESET = 1'b0;
  logic         CLOCK_DR = 1'b0;
  logic         CAPTURE_DR = 1'b0;
  logic         SHIFT_DR = 1'b0;
  logic         UPDATE_DR = 1'b0;
  logic         TDI = 1'b0;
  logic [W-1:0] DATA_IN = '0;
  logic         DATA_VALID = 1'b0;
  logic         DATA_READY;
  logic         TDO;
  logic         CAPTURED;
  logic         OVERFLOW;

  always #5 CLOCK_DR = ~CLOCK_DR;

  jtag_tx_register #(.DATA_WIDTH(W)) dut (
    .RESET      (RESET),
    .CLOCK_DR   (CLOCK_DR),
    .CAPTURE_DR (CAPTURE_DR),
    .SHIFT_DR   (SHIFT_DR),
    .UPDATE_DR  (UPDATE_DR),
    .TDI        (TDI),
    .DATA_IN    (DATA_IN),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .TDO        (TDO),
    .CAPTURED   (CAPTURED),
    .OVERFLOW   (OVERFLOW)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the DR is a bit queue whose head is TDO.
  bit         m_hf, m_ovf, m_short, m_armed, m_cap;
  bit [W-1:0] m_hd;
  int         m_cnt;
  bit         m_q[$];

  task automatic m_reset();
    m_hf = 0; m_hd = '0; m_ovf = 0; m_short = 0; m_armed = 0; m_cnt = 0; m_cap = 0;
    m_q.delete();
    for (int i = 0; i < L; i++) m_q.push_back(1'b0);
  endtask

  task automatic cycle(input bit cap, input bit sh, input bit upd, input bit tdi,
                       input bit valid, input logic [W-1:0] din);
    bit old_hf;
    CAPTURE_DR = cap; SHIFT_DR = sh; UPDATE_DR = upd; TDI = tdi;
    DATA_VALID = valid; DATA_IN = din;
    // negedge update happens before the next posedge
    if (upd) begin
      if (m_armed && m_cnt != L) m_short = 1;
      m_armed = 0;
    end
    old_hf = m_hf;
    m_cap = cap && old_hf;
    if (cap) begin
      m_q.delete();
      m_q.push_back(old_hf);
      m_q.push_back(m_ovf);
      m_q.push_back(m_short);
      for (int i = 0; i < W; i++) m_q.push_back(m_hd[i]);
      m_armed = old_hf; m_cnt = 0; m_hf = 0; m_ovf = 0; m_short = 0;
    end else if (sh) begin
      void'(m_q.pop_front());
      m_q.push_back(tdi);
      if (m_cnt < L) m_cnt++;
    end
    if (valid) begin
      if (old_hf) m_ovf = 1;
      else begin
        m_hd = din; m_hf = 1;
      end
    end
    @(posedge CLOCK_DR);
    #1;
    check("model_tdo", TDO, m_q[0]);
    check("model_ready", DATA_READY, !m_hf);
    check("model_captured", CAPTURED, m_cap);
    check("model_overflow", OVERFLOW, m_ovf);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, '0);
  endtask

  typedef struct {
    bit         cap, sh, valid;
    logic [W-1:0] din;
    bit         tdo, rdy, capd, ovf;
  } vec_t;

  initial begin
    vec_t tbl[7];
    logic [31:0] bits;
    tbl[0] = '{0, 0, 1, 16'h1111, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 16'h2222, 0, 0, 0, 1};
    tbl[2] = '{1, 0, 0, 16'h0000, 1, 1, 1, 0};
    tbl[3] = '{0, 1, 0, 16'h0000, 1, 1, 0, 0};
    tbl[4] = '{0, 1, 0, 16'h0000, 0, 1, 0, 0};
    tbl[5] = '{0, 1, 0, 16'h0000, 1, 1, 0, 0};
    tbl[6] = '{0, 1, 0, 16'h0000, 0, 1, 0, 0};

    m_reset();
    #12 RESET = 1'b1;
    @(posedge CLOCK_DR);
    #1;
    check("reset_tdo", TDO, 0);
    check("reset_ready", DATA_READY, 1);
    check("reset_captured", CAPTURED, 0);
    check("reset_overflow", OVERFLOW, 0);

    // Overflow scenario as a vector table
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].cap, tbl[i].sh, 0, 0, tbl[i].valid, tbl[i].din);
      check($sformatf("tbl%0d_tdo", i), TDO, tbl[i].tdo);
      check($sformatf("tbl%0d_ready", i), DATA_READY, tbl[i].rdy);
      check($sformatf("tbl%0d_captured", i), CAPTURED, tbl[i].capd);
      check($sformatf("tbl%0d_overflow", i), OVERFLOW, tbl[i].ovf);
    end

    // Empty capture: status bits all zero, no CAPTURED pulse
    cycle(1, 0, 0, 0, 0, '0);
    bits = 0;
    bits[0] = TDO;
    check("empty_captured", CAPTURED, 0);
    cycle(0, 1, 0, 0, 0, '0); bits[1] = TDO;
    cycle(0, 1, 0, 0, 0, '0); bits[2] = TDO;
    check("empty_status", bits, 32'h0);

    // Full 19-bit read of 0xA5C3
    cycle(0, 0, 0, 0, 1, 16'hA5C3);
    check("push_ready_low", DATA_READY, 0);
    cycle(1, 0, 0, 0, 0, '0);
    check("a5c3_captured", CAPTURED, 1);
    check("a5c3_ready_back", DATA_READY, 1);
    bits = 0;
    bits[0] = TDO;
    for (int k = 1; k < L; k++) begin
      cycle(0, 1, 0, 0, 0, '0);
      if (k == 1) check("a5c3_pulse_once", CAPTURED, 0);
      bits[k] = TDO;
    end
    cycle(0, 1, 0, 0, 0, '0);
    check("a5c3_frame", bits, {13'h0, 16'hA5C3, 3'b001});
    cycle(0, 0, 1, 0, 0, '0);

    // Truncated scan sets SHORT_READ in the next frame
    cycle(0, 0, 0, 0, 1, 16'h00FF);
    cycle(1, 0, 0, 0, 0, '0);
    for (int k = 0; k < 10; k++) cycle(0, 1, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, 0, '0);
    cycle(0, 0, 0, 0, 1, 16'h0001);
    cycle(1, 0, 0, 0, 0, '0);
    bits = 0;
    bits[0] = TDO;
    cycle(0, 1, 0, 0, 0, '0); bits[1] = TDO;
    cycle(0, 1, 0, 0, 0, '0); bits[2] = TDO;
    check("short_status", bits, 32'h5);
    for (int k = 2; k < L; k++) cycle(0, 1, 0, 0, 0, '0);
    cycle(0, 0, 1, 0, 0, '0);
    cycle(1, 0, 0, 0, 0, '0);
    bits = 0;
    bits[0] = TDO;
    cycle(0, 1, 0, 0, 0, '0); bits[1] = TDO;
    cycle(0, 1, 0, 0, 0, '0); bits[2] = TDO;
    check("short_cleared", bits, 32'h0);

    // Push on the capture edge, empty then full buffer
    cycle(1, 0, 0, 0, 1, 16'hBEEF);
    check("cap_push_empty_captured", CAPTURED, 0);
    check("cap_push_empty_valid", TDO, 0);
    check("cap_push_empty_held", DATA_READY, 0);
    cycle(1, 0, 0, 0, 0, '0);
    check("cap_push_held_captured", CAPTURED, 1);
    check("cap_push_held_valid", TDO, 1);
    cycle(0, 0, 0, 0, 1, 16'h1234);
    cycle(1, 0, 0, 0, 1, 16'h5678);
    check("cap_push_full_captured", CAPTURED, 1);
    check("cap_push_full_overflow", OVERFLOW, 1);
    check("cap_push_full_ready", DATA_READY, 1);

    // Asynchronous reset mid-shift
    cycle(0, 0, 0, 0, 1, 16'hFFFF);
    cycle(1, 0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, 1, 16'h0009);
    cycle(0, 0, 0, 0, 1, 16'h000A);
    for (int k = 0; k < 7; k++) cycle(0, 1, 0, 1, 0, '0);
    check("pre_reset_tdo", TDO, 1);
    RESET = 1'b0;
    #1;
    check("midreset_tdo", TDO, 0);
    check("midreset_ready", DATA_READY, 1);
    check("midreset_overflow", OVERFLOW, 0);
    m_reset();
    #1 RESET = 1'b1;
    cycle(1, 0, 0, 0, 0, '0);
    check("postreset_valid", TDO, 0);
    check("postreset_captured", CAPTURED, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 8) == 0, ($urandom % 3) != 0, ($urandom % 10) == 0, 1'($urandom),
            1'($urandom), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
